// File: rtl/cust_gen.sv
// Customer generator: emits bursts of numbered customers with fixed or
// pseudo-random service times, spaced by a programmable idle gap.
//
//  state  | meaning
//  -------+---------------------------------------------------------
//  S_IDLE | waiting for start; outputs hold, busy low
//  S_EMIT | one-cycle customer strobe on out_valid
//  S_GAP  | idle cycles between customers, counted down from gap
module cust_gen #(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       stop,
   input  logic [3:0] burst_len,
   input  logic [3:0] gap,
   input  logic       fix_en,
   input  logic [3:0] fix_time,
   output logic       out_valid,
   output logic [3:0] out_num,
   output logic [3:0] out_time,
   output logic       busy,
   output logic       done,
   output logic [7:0] sent_cnt
);

   // An all-zero seed would lock the LFSR, so it is replaced by 1.
   localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EMIT = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;

   logic [3:0] r_gap;
   logic       r_fix_en;
   logic [3:0] r_fix_time;
   logic       r_cont;
   logic [3:0] r_left;
   logic [3:0] r_gap_cnt;
   logic [7:0] r_lfsr;
   logic [3:0] r_next_num;

   logic       w_emit;
   logic       w_start;
   logic       w_fix_en;
   logic [3:0] w_fix_t;
   logic [3:0] w_time;
   logic [3:0] w_left_now;
   logic       w_cont;
   logic       w_last;
   logic       w_lfsr_fb;

   // Next-state decode; stop wins over every other transition out of a busy state.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (start && !stop) w_state_nxt = S_EMIT;
         end
         S_EMIT: begin
            if (stop)                          w_state_nxt = S_IDLE;
            else if (!r_cont && r_left == 4'd0) w_state_nxt = S_IDLE;
            else if (r_gap == 4'd0)            w_state_nxt = S_EMIT;
            else                               w_state_nxt = S_GAP;
         end
         S_GAP: begin
            if (stop)                   w_state_nxt = S_IDLE;
            else if (r_gap_cnt == 4'd0) w_state_nxt = S_EMIT;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // The first emission of a burst happens on the start edge itself, so it
   // must see the live configuration inputs rather than the latched copies.
   always_comb begin
      w_emit     = (w_state_nxt == S_EMIT);
      w_start    = (r_state == S_IDLE) && w_emit;
      w_fix_en   = w_start ? fix_en    : r_fix_en;
      w_fix_t    = w_start ? fix_time  : r_fix_time;
      w_left_now = w_start ? burst_len : r_left;
      w_cont     = w_start ? (burst_len == 4'd0) : r_cont;
      w_last     = !w_cont && (w_left_now == 4'd1);
      w_lfsr_fb  = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
      if (w_fix_en)
         w_time = (w_fix_t == 4'd0) ? 4'd1 : w_fix_t;
      else
         w_time = (r_lfsr[3:0] == 4'd0) ? 4'd1 : r_lfsr[3:0];
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   // Burst configuration, remaining-customer and gap down-counters, LFSR and numbering.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_gap      <= 4'd0;
         r_fix_en   <= 1'b0;
         r_fix_time <= 4'd0;
         r_cont     <= 1'b0;
         r_left     <= 4'd0;
         r_gap_cnt  <= 4'd0;
         r_lfsr     <= SEED_EFF;
         r_next_num <= 4'd1;
      end else begin
         if (w_start) begin
            r_gap      <= gap;
            r_fix_en   <= fix_en;
            r_fix_time <= fix_time;
            r_cont     <= (burst_len == 4'd0);
         end
         if (w_emit) begin
            if (!w_cont) r_left <= w_left_now - 4'd1;
            r_lfsr     <= {r_lfsr[6:0], w_lfsr_fb};
            r_next_num <= (r_next_num == 4'd15) ? 4'd1 : r_next_num + 4'd1;
         end
         if (w_state_nxt == S_GAP) begin
            if (r_state == S_EMIT) r_gap_cnt <= r_gap - 4'd1;
            else                   r_gap_cnt <= r_gap_cnt - 4'd1;
         end
      end
   end

   // Registered outputs; number and time only change on an emission.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_num   <= 4'd0;
         out_time  <= 4'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         sent_cnt  <= 8'd0;
      end else begin
         out_valid <= w_emit;
         busy      <= (w_state_nxt != S_IDLE);
         done      <= w_emit && w_last;
         if (w_emit) begin
            out_num  <= r_next_num;
            out_time <= w_time;
         end
         if (w_start)
            sent_cnt <= 8'd1;
         else if (w_emit && sent_cnt != 8'd255)
            sent_cnt <= sent_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_cust_gen.sv
// Directed bench for cust_gen with a reference LFSR for random service times.
module tb_cust_gen;

   logic       clk;
   logic       rst;
   logic       start;
   logic       stop;
   logic [3:0] burst_len;
   logic [3:0] gap;
   logic       fix_en;
   logic [3:0] fix_time;
   logic       out_valid;
   logic [3:0] out_num;
   logic [3:0] out_time;
   logic       busy;
   logic       done;
   logic [7:0] sent_cnt;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   cust_gen #(.SEED(8'hA5)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .stop      (stop),
      .burst_len (burst_len),
      .gap       (gap),
      .fix_en    (fix_en),
      .fix_time  (fix_time),
      .out_valid (out_valid),
      .out_num   (out_num),
      .out_time  (out_time),
      .busy      (busy),
      .done      (done),
      .sent_cnt  (sent_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      chk_cnt++;
      if (got == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   // Reference LFSR: x^8+x^6+x^5+x^4+1, shift left, feedback into bit 0.
   function automatic logic [7:0] lfsr_step(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   function automatic logic [3:0] lfsr_time(input logic [7:0] v);
      return (v[3:0] == 4'd0) ? 4'd1 : v[3:0];
   endfunction

   logic [7:0] m_lfsr;
   logic [3:0] m_num;
   int         n_strobe;
   int         n_done;
   int         n_zero;

   initial begin
      rst = 1'b0; start = 1'b0; stop = 1'b0;
      burst_len = 4'd0; gap = 4'd0; fix_en = 1'b0; fix_time = 4'd0;
      #12;
      chk("rst_valid", out_valid, 0);
      chk("rst_num",   out_num,   0);
      chk("rst_time",  out_time,  0);
      chk("rst_busy",  busy,      0);
      chk("rst_done",  done,      0);
      chk("rst_sent",  sent_cnt,  0);
      @(posedge clk); #1; rst = 1'b1;

      // Fixed time 3, back-to-back burst of 3.
      fix_en = 1'b1; fix_time = 4'd3; gap = 4'd0; burst_len = 4'd3; start = 1'b1;
      tick(); start = 1'b0;
      chk("b3_v1", out_valid, 1); chk("b3_n1", out_num, 1); chk("b3_t1", out_time, 3);
      chk("b3_d1", done, 0); chk("b3_busy", busy, 1);
      tick();
      chk("b3_v2", out_valid, 1); chk("b3_n2", out_num, 2); chk("b3_t2", out_time, 3);
      tick();
      chk("b3_v3", out_valid, 1); chk("b3_n3", out_num, 3); chk("b3_d3", done, 1);
      chk("b3_sent", sent_cnt, 3);
      tick();
      chk("b3_idle_v", out_valid, 0); chk("b3_idle_busy", busy, 0);
      chk("b3_idle_done", done, 0); chk("b3_hold_num", out_num, 3);
      chk("b3_hold_time", out_time, 3);

      // fix_time 0 -> 1, gap 2, burst of 2.
      do_reset();
      fix_en = 1'b1; fix_time = 4'd0; gap = 4'd2; burst_len = 4'd2; start = 1'b1;
      tick(); start = 1'b0;
      chk("g2_v1", out_valid, 1); chk("g2_n1", out_num, 1); chk("g2_t1", out_time, 1);
      chk("g2_d1", done, 0);
      tick();
      chk("g2_gap1_v", out_valid, 0); chk("g2_gap1_busy", busy, 1);
      chk("g2_gap1_num", out_num, 1);
      tick();
      chk("g2_gap2_v", out_valid, 0); chk("g2_gap2_busy", busy, 1);
      tick();
      chk("g2_v2", out_valid, 1); chk("g2_n2", out_num, 2); chk("g2_t2", out_time, 1);
      chk("g2_d2", done, 1); chk("g2_busy2", busy, 1);
      tick();
      chk("g2_end_v", out_valid, 0); chk("g2_end_busy", busy, 0);

      // start+stop in IDLE ignored; start while busy ignored.
      do_reset();
      fix_en = 1'b1; fix_time = 4'd5; gap = 4'd1; burst_len = 4'd2;
      start = 1'b1; stop = 1'b1;
      tick();
      chk("ss_v", out_valid, 0); chk("ss_busy", busy, 0); chk("ss_sent", sent_cnt, 0);
      stop = 1'b0;
      n_strobe = 0;
      tick(); n_strobe += out_valid;
      tick(); n_strobe += out_valid;
      tick(); n_strobe += out_valid;
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick(); n_strobe += out_valid;
      end
      chk("sb_strobes", n_strobe, 2);
      chk("sb_sent", sent_cnt, 2);
      chk("sb_num", out_num, 2);
      chk("sb_time", out_time, 5);
      chk("sb_busy", busy, 0);

      // Continuous LFSR run for 300 strobes, then stop.
      do_reset();
      fix_en = 1'b0; gap = 4'd0; burst_len = 4'd0; start = 1'b1;
      m_lfsr = 8'hA5; m_num = 4'd1; n_done = 0; n_zero = 0;
      for (int i = 0; i < 300; i++) begin
         tick(); start = 1'b0;
         chk("cont_v", out_valid, 1);
         chk("cont_num", out_num, m_num);
         chk("cont_time", out_time, lfsr_time(m_lfsr));
         n_done += done;
         if (out_num == 4'd0 || out_time == 4'd0) n_zero++;
         m_lfsr = lfsr_step(m_lfsr);
         m_num  = (m_num == 4'd15) ? 4'd1 : m_num + 4'd1;
      end
      chk("cont_no_done", n_done, 0);
      chk("cont_no_zero", n_zero, 0);
      chk("cont_sent_sat", sent_cnt, 255);
      stop = 1'b1;
      tick(); stop = 1'b0;
      chk("stop_v", out_valid, 0); chk("stop_busy", busy, 0); chk("stop_done", done, 0);
      tick();
      chk("stop_still_idle", out_valid, 0);

      // Reset during GAP of a 5-customer burst.
      do_reset();
      fix_en = 1'b1; fix_time = 4'd2; gap = 4'd3; burst_len = 4'd5; start = 1'b1;
      tick(); start = 1'b0;
      chk("rg_v1", out_valid, 1); chk("rg_n1", out_num, 1); chk("rg_t1", out_time, 2);
      tick();
      chk("rg_gap_v", out_valid, 0); chk("rg_gap_busy", busy, 1);
      #2 rst = 1'b0;
      #1;
      chk("rg_rst_num", out_num, 0); chk("rg_rst_time", out_time, 0);
      chk("rg_rst_busy", busy, 0); chk("rg_rst_sent", sent_cnt, 0);
      @(posedge clk); #1; rst = 1'b1;
      n_strobe = 0;
      for (int i = 0; i < 6; i++) begin
         tick(); n_strobe += out_valid;
      end
      chk("rg_quiet", n_strobe, 0);
      fix_en = 1'b0; start = 1'b1;
      tick(); start = 1'b0;
      chk("rg_restart_v", out_valid, 1);
      chk("rg_restart_num", out_num, 1);
      chk("rg_restart_time", out_time, lfsr_time(8'hA5));
      tick();
      chk("rg_restart_gap", out_valid, 0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule

// File: doc/cust_gen.md
CUST_GEN -- requirements
Module: cust_gen

Interface
REQ-001 SHALL have parameter SEED, default 8'hA5, the LFSR reset value; 8'h00 is replaced by 8'h01.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on posedge clk.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, begin a burst, sampled at posedge.
REQ-005 SHALL have port stop, input, 1, abort the running burst, sampled at posedge.
REQ-006 SHALL have port burst_len, input, 4, customers per burst; 0 = continuous.
REQ-007 SHALL have port gap, input, 4, idle cycles between customers.
REQ-008 SHALL have port fix_en, input, 1, 1 = use fix_time, 0 = use LFSR time.
REQ-009 SHALL have port fix_time, input, 4, fixed service time (0 is treated as 1).
REQ-010 SHALL have port out_valid, output, 1, customer strobe to the queue input (in_valid side).
REQ-011 SHALL have port out_num, output, 4, customer number, valid with out_valid.
REQ-012 SHALL have port out_time, output, 4, service time, valid with out_valid.
REQ-013 SHALL have port busy, output, 1, high in EMIT or GAP.
REQ-014 SHALL have port done, output, 1, one-cycle pulse when a finite burst completes.
REQ-015 SHALL have port sent_cnt, output, 8, customers emitted since last start, saturating.

Function
REQ-016 SHALL implement FSM IDLE, EMIT, GAP, all outputs registered.
REQ-017 IDLE: start=1 and stop=0 -> EMIT; latch burst_len, gap, fix_en, fix_time; clear sent_cnt.
REQ-018 EMIT: out_valid=1 for exactly one cycle; out_num/out_time presented in the same cycle; sent_cnt increments.
REQ-019 First out_valid SHALL occur on the cycle immediately after the edge that sampled start (latency 1).
REQ-020 After EMIT: last customer of a finite burst -> IDLE with done=1 that cycle; else gap=0 -> EMIT (back-to-back strobes); else GAP.
REQ-021 GAP: count latched gap cycles with out_valid=0, then -> EMIT.
REQ-022 out_num SHALL start at 1 after reset, increment per emission, wrap 15 -> 1, never 0; it is not reset by start.
REQ-023 LFSR SHALL be 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, period 255, advancing once per emission only.
REQ-024 LFSR time = lfsr[3:0], forced to 1 when 0; out_time range 1..15.
REQ-025 out_num/out_time SHALL hold their last values while out_valid=0.
REQ-026 stop=1 in EMIT or GAP -> IDLE next cycle; an EMIT strobe in progress is not truncated; done not pulsed.
REQ-027 stop and start both 1 in IDLE -> remain IDLE.
REQ-028 start while busy SHALL be ignored.
REQ-029 burst_len=0: run until stop; done never pulses.
REQ-030 sent_cnt SHALL saturate at 255.
REQ-031 No back-pressure: queue-full drops are the downstream's concern; emission timing is independent of it.

Reset
REQ-032 rst low SHALL asynchronously force IDLE, out_valid=0, out_num=0, out_time=0, busy=0, done=0, sent_cnt=0, gap counter=0, LFSR=SEED, next number=1.
REQ-033 Reset asserted mid-burst SHALL abort immediately, with no further strobes until a new start.
REQ-034 Operation resumes on the first posedge after rst deasserts; start sampled on that edge is honoured.

Verification
REQ-035 fix_en=1, fix_time=3, gap=0, burst_len=3, start pulse -> three consecutive strobes (1,3),(2,3),(3,3); done on the third; sent_cnt=3.
REQ-036 fix_en=1, fix_time=0, gap=2, burst_len=2 -> strobes (1,1) and (2,1) separated by exactly 2 low cycles; busy high throughout; done on the last.
REQ-037 burst_len=0, gap=0, fix_en=0, 300 cycles then stop -> out_num cycles 1..15 wrapping with no 0; out_time never 0; LFSR period 255 checked; sent_cnt=255 saturated; IDLE the cycle after stop; no done.
REQ-038 start while busy, and start+stop together in IDLE -> both ignored; strobe count unchanged.
REQ-039 rst pulsed low in GAP of a burst_len=5 run -> outputs zero immediately; no strobes until restart; next first strobe out_num=1, LFSR restarts from SEED.
REQ-040 End-to-end with the shop-queue top: fix_en=1, fix_time=4, gap=0, burst_len=7 -> counters load customers 1-3, FIFO holds 4-6, customer 7 dropped while full.
